// File: rtl/sum_pkg.sv
// sum_pkg: shared feeder state encoding and data width for the feeder and accumulator
package sum_pkg;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/feeder_buf.sv
// feeder_buf: register array with one write port and a combinational read port, no reset
module feeder_buf import sum_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sum_feeder.sv
// sum_feeder: buffers host words and streams the first n of them over valid/ready with a running checksum
module sum_feeder import sum_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic [7:0]        n_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              full_o,
    output logic [DATA_W-1:0] chk_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CNT_W > 8) ? CNT_W : 8;

    feeder_state_t     state;
    logic [CNT_W-1:0]  fill, sent;
    logic [AW-1:0]     rd_ptr;
    logic [7:0]        n;
    logic [DATA_W-1:0] rdata;
    logic              we, xfer, last;

    assign full_o = fill == CNT_W'(DEPTH);
    assign we     = state == IDLE && !start_i && !clr_i && wr_en_i && !full_o;
    assign xfer   = valid_o && ready_i;
    assign last   = CW'(sent) + CW'(1) == CW'(n);
    assign data_o = valid_o ? rdata : '0;

    feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk_i),
        .we    (we),
        .waddr (fill[AW-1:0]),
        .wdata (wr_data_i),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            fill    <= '0;
            sent    <= '0;
            rd_ptr  <= '0;
            n       <= '0;
            chk_o   <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (n_i == 8'd0) begin
                            state  <= DONE;
                            chk_o  <= '0;
                            done_o <= 1'b1;
                        end else if (CW'(n_i) > CW'(fill)) begin
                            err_o <= 1'b1;
                        end else begin
                            n       <= n_i;
                            rd_ptr  <= '0;
                            sent    <= '0;
                            chk_o   <= '0;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b1;
                            state   <= STREAM;
                        end
                    end else if (clr_i) begin
                        fill <= '0;
                    end else if (we) begin
                        fill <= fill + CNT_W'(1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        chk_o  <= chk_o + rdata;
                        rd_ptr <= rd_ptr + AW'(1);
                        sent   <= sent + CNT_W'(1);
                        if (last) begin
                            state   <= DONE;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_feeder.sv
// tb_sum_feeder: randomized and directed stimulus against a queue-level reference model of the feeder
module tb_sum_feeder;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       clr = 1'b0, wr_en = 1'b0, start = 1'b0, ready = 1'b0;
    logic [7:0] wr_data = '0, n = '0;
    logic [7:0] data_o, chk_o;
    logic       valid_o, busy_o, done_o, err_o, full_o;

    int passed = 0, total = 0;

    sum_feeder dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .start_i(start), .n_i(n), .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .full_o(full_o), .chk_o(chk_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: buffer contents, a mode (0 idle, 1 streaming, 2 done), position, length, checksum
    logic [7:0] mem_m [16];
    int         mfill, mode, idx, mn;
    logic [7:0] mchk;
    logic       merr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mfill <= 0; mode <= 0; idx <= 0; mn <= 0; mchk <= '0; merr <= 1'b0;
        end else begin
            merr <= 1'b0;
            if (mode == 2) mode <= 0;
            else if (mode == 1) begin
                if (ready) begin
                    mchk <= mchk + mem_m[idx];
                    idx  <= idx + 1;
                    if (idx + 1 == mn) mode <= 2;
                end
            end else if (start) begin
                if (n == 0) begin mode <= 2; mchk <= '0; end
                else if (int'(n) > mfill) merr <= 1'b1;
                else begin mn <= int'(n); idx <= 0; mchk <= '0; mode <= 1; end
            end else if (clr) mfill <= 0;
            else if (wr_en && mfill < 16) begin
                mem_m[mfill] <= wr_data;
                mfill <= mfill + 1;
            end
        end
    end

    int         cyc_n = 0, last_xfer = 0, done_cyc = 0;
    bit         done_flag = 0;
    logic [7:0] got [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        check("valid", 32'(valid_o), 32'(mode == 1));
        check("busy",  32'(busy_o),  32'(mode == 1));
        check("data",  32'(data_o),  32'((mode == 1) ? mem_m[idx] : 8'd0));
        check("done",  32'(done_o),  32'(mode == 2));
        check("err",   32'(err_o),   32'(merr));
        check("full",  32'(full_o),  32'(mfill == 16));
        check("chk",   32'(chk_o),   32'(mchk));
        if (valid_o && ready) begin got.push_back(data_o); last_xfer = cyc_n; end
        if (done_o) begin done_flag = 1; done_cyc = cyc_n; end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic load(input logic [7:0] w);
        wr_en = 1'b1; wr_data = w; step(); wr_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic go(input logic [7:0] cnt);
        got.delete(); done_flag = 0;
        start = 1'b1; n = cnt; step(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_flag; i++) step();
        check("done_seen", 32'(done_flag), 32'd1);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp [$]);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, 32'(got[i]), 32'(exp[i]));
    endtask

    logic [7:0] w16 [$];
    bit   [6:0] pat = 7'b1011001;

    initial begin
        repeat (3) step();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_chk", 32'(chk_o), 32'd0);
        rst_n = 1'b1;
        step();

        load(8'd3); load(8'd5); load(8'd7);
        ready = 1'b1;
        go(8'd3);
        check("first_word", 32'(data_o), 32'd3);
        wait_done(20);
        check_got("basic", '{8'd3, 8'd5, 8'd7});
        check("basic_chk", 32'(chk_o), 32'd15);
        check("done_lat", 32'(done_cyc), 32'(last_xfer + 1));

        do_clr();
        load(8'd10); load(8'd20); load(8'd30); load(8'd40);
        ready = 1'b0;
        go(8'd4);
        for (int i = 0; i < 7; i++) begin ready = pat[i]; step(); end
        ready = 1'b1;
        wait_done(20);
        check_got("bp", '{8'd10, 8'd20, 8'd30, 8'd40});
        check("bp_chk", 32'(chk_o), 32'd100);

        do_clr();
        load(8'd200); load(8'd100);
        go(8'd2);
        wait_done(20);
        check("wrap_chk", 32'(chk_o), 32'd44);
        go(8'd0);
        check("n0_done", 32'(done_o), 32'd1);
        check("n0_chk", 32'(chk_o), 32'd0);
        step();

        do_clr();
        for (int i = 0; i < 17; i++) begin
            w16.push_back(8'($urandom));
            load(w16[i]);
        end
        check("full", 32'(full_o), 32'd1);
        void'(w16.pop_back());
        go(8'd17);
        check("n17_err", 32'(err_o), 32'd1);
        check("n17_busy", 32'(busy_o), 32'd0);
        step();
        check("n17_err_clr", 32'(err_o), 32'd0);
        go(8'd16);
        for (int i = 0; i < 400 && !done_flag; i++) begin
            ready = 1'($urandom); start = 1'($urandom); clr = 1'($urandom);
            wr_en = 1'($urandom); wr_data = 8'($urandom); n = 8'($urandom);
            step();
        end
        start = 1'b0; clr = 1'b0; wr_en = 1'b0; ready = 1'b1;
        check("n16_done", 32'(done_flag), 32'd1);
        check_got("n16", w16);
        go(8'd2);
        wait_done(20);
        check_got("replay", '{w16[0], w16[1]});

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) do_clr();
            repeat ($urandom_range(0, 6)) load(8'($urandom));
            go(8'($urandom_range(0, mfill + 2)));
            if (mode == 1) begin
                for (int i = 0; i < 300 && !done_flag; i++) begin ready = 1'($urandom); step(); end
                check("rand_done", 32'(done_flag), 32'd1);
            end
            ready = 1'b1;
            step();
        end

        do_clr();
        foreach (w16[i]) if (i < 5) load(8'(11 * (i + 1)));
        go(8'd5);
        step(); step();
        rst_n = 1'b0; #1;
        check("arst_xfers", 32'(got.size()), 32'd2);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_data", 32'(data_o), 32'd0);
        check("arst_chk", 32'(chk_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("arst_no_done", 32'(done_flag), 32'd0);
        go(8'd1);
        check("arst_err", 32'(err_o), 32'd1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sum_feeder.md
Name: sum_feeder

Overview:
Producer end of the accumulator data interface. It buffers a block of 8-bit words loaded by a host, then on start streams the first N words out on a valid/ready interface to the summing block, one word per accepted transfer. It keeps a mod-256 checksum of the words it sends so the sum reported by the consumer can be checked against it. It sits between the host/test stimulus and the accumulator.

Parameters:
DATA_W, 8, width of data words and checksum
DEPTH, 16, buffer capacity in words (power of two, ≥2)
CNT_W, $clog2(DEPTH)+1, width of fill and transfer counters

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous buffer clear (fill count to 0), honoured in IDLE only
wr_en_i  in  1  load strobe, honoured in IDLE only
wr_data_i  in  DATA_W  word to load
start_i  in  1  begin streaming, honoured in IDLE only
n_i  in  8  number of words to stream
data_o  out  DATA_W  current word (mem[rd_ptr])
valid_o  out  1  data_o valid
ready_i  in  1  consumer accepts data_o
busy_o  out  1  high in STREAM
done_o  out  1  one-cycle pulse at end of stream
err_o  out  1  one-cycle pulse on rejected start
full_o  out  1  fill count == DEPTH
chk_o  out  DATA_W  mod-2^DATA_W sum of words sent in the current/last stream

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; fill, rd_ptr, sent counters=0; valid_o, busy_o, done_o, err_o=0; chk_o=0; data_o=0. Buffer memory is not reset (contents don't-care). Reset mid-stream aborts immediately; no done_o.
- States: IDLE, STREAM, DONE (shared enum, 2 bits).
- IDLE load: wr_en_i=1 and fill<DEPTH -> mem[fill]<=wr_data_i, fill+1. At fill==DEPTH the write is dropped and fill holds. clr_i=1 -> fill<=0; clr_i takes priority over wr_en_i in the same cycle.
- IDLE start (start_i=1; takes priority over wr_en_i/clr_i in the same cycle, which are then ignored):
  - n_i==0 -> DONE next cycle, chk_o<=0.
  - n_i>fill (compare zero-extended to max(8,CNT_W)) -> err_o=1 for the next cycle, stay IDLE, nothing else changes.
  - otherwise latch n<=n_i, rd_ptr<=0, sent<=0, chk_o<=0, go to STREAM.
- STREAM: valid_o=1, busy_o=1, data_o=mem[rd_ptr] (combinational read from register array).
  - Transfer happens when valid_o&&ready_i: chk_o<=chk_o+data_o (wraps mod 256), rd_ptr+1, sent+1.
  - When the transfer with sent==n-1 completes, go to DONE.
  - ready_i low: hold all outputs stable, with data_o unchanged. There is no timeout.
  - start_i, wr_en_i and clr_i are ignored in STREAM.
- DONE: done_o=1 for exactly one cycle, valid_o=0, then IDLE.
  - chk_o holds until the next accepted start.
  - Buffer and fill are retained, so a subsequent start replays from word 0.
- First word is offered the cycle after start is accepted. Full-throughput latency is 1 + n cycles from start to the last transfer; done_o is asserted the cycle after the last transfer.
- data_o is driven 0 outside STREAM.

Decomposition:
- Package sum_pkg holds:
  - feeder_state_t enum (IDLE=0, STREAM=1, DONE=2);
  - DATA_W default constant;
  - shared with the accumulator so the data width stays consistent.
- One sub-module, feeder_buf: DEPTH×DATA_W register array with write port (we, waddr, wdata) and combinational read (raddr, rdata), no reset.
- FSM, counters and checksum live in sum_feeder.

Test Plan:
- Reset and idle outputs: load 3,5,7 via wr_en_i, start n=3, ready_i=1 -> data_o 3,5,7 on consecutive cycles; done_o pulses one cycle after the 7 transfer; chk_o=15.
- Backpressure: load 10,20,30,40, start n=4, toggle ready_i 1,0,0,1,1,0,1 -> each word held while ready_i=0, no duplicates or drops; chk_o=100.
- Checksum wrap: load 200,100 and start n=2 -> chk_o=44 (300 mod 256). Then start n=0 -> done_o next cycle, chk_o=0.
- Bounds: load 16 words with a 17th wr_en_i -> 17th dropped, full_o=1. Start n=17 -> err_o one cycle, stays IDLE. Start n=16 -> all 16 words streamed.
- Ignored controls: during STREAM, assert start_i, wr_en_i and clr_i -> no effect on the stream or buffer. After done_o, start n=2 -> replays words 0 and 1.
- Async reset mid-stream: drop rst_ni after 2 of 5 transfers -> all outputs 0 immediately, no done_o; after release, fill=0 and start n=1 -> err_o.
